// File: rtl/adder_tree_pkg.sv
// rtl/adder_tree_pkg.sv - sizing helpers shared by the pipelined adder tree
package adder_tree_pkg;

    // ceil(log2(v)) for v >= 1
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // number of register levels needed to reduce n operands to one
    function automatic int levels_of(input int n);
        return clog2(n);
    endfunction

    // exact result width: one growth bit per level
    function automatic int out_width_of(input int n, input int w);
        return w + clog2(n);
    endfunction

    // operand count rounded up to the next power of two
    function automatic int padded_count(input int n);
        return 1 << clog2(n);
    endfunction

    // bit offset of level k inside the flattened tree bus (level 0 = padded operands)
    function automatic int level_offset(input int p, input int w, input int k);
        int off;
        off = 0;
        for (int j = 0; j < k; j++) begin
            off = off + (p >> j) * (w + j);
        end
        return off;
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// rtl/adder_tree_level.sv - one registered pairwise-add level of the adder tree
module adder_tree_level #(
    parameter int IN_COUNT = 8,
    parameter int WIDTH    = 8,
    parameter int SIGNED   = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 adv,
    input  logic                                 in_valid,
    input  logic                                 in_last,
    input  logic [IN_COUNT*WIDTH-1:0]            in_data,
    output logic                                 out_valid,
    output logic                                 out_last,
    output logic [(IN_COUNT/2)*(WIDTH+1)-1:0]    out_data
);

    localparam int OUT_COUNT = IN_COUNT / 2;
    localparam int OW        = WIDTH + 1;

    logic [OUT_COUNT*OW-1:0] sum;

    for (genvar j = 0; j < OUT_COUNT; j++) begin : g_pair
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sa;
        logic             sb;
        assign a  = in_data[(2*j)*WIDTH +: WIDTH];
        assign b  = in_data[(2*j+1)*WIDTH +: WIDTH];
        assign sa = (SIGNED != 0) && a[WIDTH-1];
        assign sb = (SIGNED != 0) && b[WIDTH-1];
        assign sum[j*OW +: OW] = {sa, a} + {sb, b};
    end

    // advance the level (data, valid, last) only when the whole pipe moves
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (adv) begin
            out_valid <= in_valid;
            out_last  <= in_last;
            out_data  <= sum;
        end
    end

endmodule

// File: rtl/adder_tree_pipelined.sv
// rtl/adder_tree_pipelined.sv - pipelined adder tree with global stall; ADDER_TREE_ACCUM_EN adds a frame accumulator
module adder_tree_pipelined
    import adder_tree_pkg::*;
#(
    parameter int N_INPUTS  = 8,
    parameter int IN_WIDTH  = 8,
    parameter int SIGNED    = 0,
    parameter int ACC_WIDTH = 24
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [N_INPUTS*IN_WIDTH-1:0]                  in_data,
    input  logic                                          in_last,
    output logic                                          out_valid,
    input  logic                                          out_ready,
`ifdef ADDER_TREE_ACCUM_EN
    output logic [ACC_WIDTH-1:0]                          out_sum
`else
    output logic [out_width_of(N_INPUTS, IN_WIDTH)-1:0]   out_sum
`endif
);

    localparam int LEVELS    = levels_of(N_INPUTS);
    localparam int OUT_WIDTH = out_width_of(N_INPUTS, IN_WIDTH);
    localparam int P         = padded_count(N_INPUTS);
    localparam int TREE_BITS = level_offset(P, IN_WIDTH, LEVELS + 1);
    localparam int LO_FINAL  = level_offset(P, IN_WIDTH, LEVELS);

    logic [TREE_BITS-1:0] tree;
    logic [LEVELS:0]      stage_valid;
    logic [LEVELS:0]      stage_last;
    logic                 adv;
    logic [OUT_WIDTH-1:0] tree_sum;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign stage_valid[0] = in_valid;
    assign stage_last[0]  = in_last;

    // padding operands are hard zero so they never disturb a signed sum
    if (P > N_INPUTS) begin : g_pad
        assign tree[P*IN_WIDTH-1:0] = {{((P - N_INPUTS) * IN_WIDTH){1'b0}}, in_data};
    end else begin : g_nopad
        assign tree[P*IN_WIDTH-1:0] = in_data;
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        localparam int CNT    = P >> (k - 1);
        localparam int WI     = IN_WIDTH + k - 1;
        localparam int LO_IN  = level_offset(P, IN_WIDTH, k - 1);
        localparam int LO_OUT = level_offset(P, IN_WIDTH, k);
        adder_tree_level #(
            .IN_COUNT (CNT),
            .WIDTH    (WI),
            .SIGNED   (SIGNED)
        ) u_level (
            .clk       (clk),
            .reset     (reset),
            .adv       (adv),
            .in_valid  (stage_valid[k-1]),
            .in_last   (stage_last[k-1]),
            .in_data   (tree[LO_IN +: CNT*WI]),
            .out_valid (stage_valid[k]),
            .out_last  (stage_last[k]),
            .out_data  (tree[LO_OUT +: (CNT/2)*(WI+1)])
        );
    end

    assign tree_sum = tree[LO_FINAL +: OUT_WIDTH];

`ifdef ADDER_TREE_ACCUM_EN
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] beat_ext;
    logic                 beat_sign;

    assign beat_sign = (SIGNED != 0) && tree_sum[OUT_WIDTH-1];
    assign beat_ext  = {{(ACC_WIDTH - OUT_WIDTH){beat_sign}}, tree_sum};

    // fold each tree beat into acc; only the last beat of a frame is presented downstream
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
        end else if (adv) begin
            if (stage_valid[LEVELS]) begin
                if (stage_last[LEVELS]) begin
                    out_sum   <= acc + beat_ext;
                    out_valid <= 1'b1;
                    acc       <= '0;
                end else begin
                    acc       <= acc + beat_ext;
                    out_valid <= 1'b0;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
`else
    logic unused_last;
    localparam int unused_acc_width = ACC_WIDTH;

    assign unused_last = stage_last[LEVELS];
    assign out_valid   = stage_valid[LEVELS];
    assign out_sum     = tree_sum;
`endif

endmodule

// File: tb/tb_adder_tree_pipelined.sv
// tb/tb_adder_tree_pipelined.sv - directed self-checking bench for adder_tree_pipelined
module tb_adder_tree_pipelined;

`ifdef ADDER_TREE_ACCUM_EN
    localparam int OW = 24;
`else
    localparam int OW = 11;
`endif

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_last;
    logic          out_ready;
    logic [63:0]   d_u8;
    logic [63:0]   d_s8;
    logic [39:0]   d_n5;
    logic          rdy_u8, rdy_s8, rdy_n5;
    logic          ov_u8, ov_s8, ov_n5;
    logic [OW-1:0] os_u8, os_s8, os_n5;
    logic [7:0]    bv;

    int total;
    int bad;

    adder_tree_pipelined #(.N_INPUTS(8), .IN_WIDTH(8), .SIGNED(0), .ACC_WIDTH(24)) u_u8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_u8), .in_data(d_u8),
        .in_last(in_last), .out_valid(ov_u8), .out_ready(out_ready), .out_sum(os_u8)
    );

    adder_tree_pipelined #(.N_INPUTS(8), .IN_WIDTH(8), .SIGNED(1), .ACC_WIDTH(24)) u_s8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_s8), .in_data(d_s8),
        .in_last(in_last), .out_valid(ov_s8), .out_ready(out_ready), .out_sum(os_s8)
    );

    adder_tree_pipelined #(.N_INPUTS(5), .IN_WIDTH(8), .SIGNED(0), .ACC_WIDTH(24)) u_n5 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_n5), .in_data(d_n5),
        .in_last(in_last), .out_valid(ov_n5), .out_ready(out_ready), .out_sum(os_n5)
    );

`ifdef ADDER_TREE_ACCUM_EN
    logic        v12, l12, rdy12, ov12;
    logic [63:0] d12;
    logic [11:0] os12;

    adder_tree_pipelined #(.N_INPUTS(8), .IN_WIDTH(8), .SIGNED(0), .ACC_WIDTH(12)) u_w12 (
        .clk(clk), .reset(reset), .in_valid(v12), .in_ready(rdy12), .in_data(d12),
        .in_last(l12), .out_valid(ov12), .out_ready(out_ready), .out_sum(os12)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        d_u8      = '0;
        d_s8      = '0;
        d_n5      = '0;
        bv        = '0;
`ifdef ADDER_TREE_ACCUM_EN
        v12 = 1'b0;
        l12 = 1'b0;
        d12 = '0;
`endif
        step;
        step;
        chk("rst_valid", 32'(ov_u8), 32'd0);
        chk("rst_sum", 32'(os_u8), 32'd0);
        reset = 1'b0;
        step;
        chk("rst_ready", 32'(rdy_u8), 32'd1);
        chk("idle_valid", 32'(ov_u8), 32'd0);

`ifndef ADDER_TREE_ACCUM_EN
        // single vector: latency and the three parameterisations
        in_valid = 1'b1;
        d_u8 = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        d_s8 = {8{8'h80}};
        d_n5 = {8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        step;
        in_valid = 1'b0;
        step;
        chk("lat_early", 32'(ov_u8), 32'd0);
        step;
        chk("u8_valid", 32'(ov_u8), 32'd1);
        chk("u8_sum_1to8", 32'(os_u8), 32'd36);
        chk("s8_valid", 32'(ov_s8), 32'd1);
        chk("s8_all_min", 32'(os_s8), 32'h400);
        chk("n5_valid", 32'(ov_n5), 32'd1);
        chk("n5_sum", 32'(os_n5), 32'd150);
        step;
        chk("single_drop", 32'(ov_u8), 32'd0);

        // three vectors back to back
        in_valid = 1'b1;
        d_u8 = {8{8'hFF}};
        d_s8 = {8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h80, 8'h7F};
        d_n5 = {5{8'hFF}};
        step;
        d_s8 = {8{8'h01}};
        d_n5 = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        step;
        d_s8 = {8{8'hFF}};
        d_n5 = {5{8'h01}};
        step;
        in_valid = 1'b0;
        chk("b2b_a_u8", 32'(os_u8), 32'd2040);
        chk("b2b_a_s8", 32'(os_s8), 32'd0);
        chk("b2b_a_n5", 32'(os_n5), 32'd1275);
        step;
        chk("b2b_b_valid", 32'(ov_u8), 32'd1);
        chk("b2b_b_u8", 32'(os_u8), 32'd2040);
        chk("b2b_b_s8", 32'(os_s8), 32'd8);
        chk("b2b_b_n5", 32'(os_n5), 32'd15);
        step;
        chk("b2b_c_valid", 32'(ov_u8), 32'd1);
        chk("b2b_c_u8", 32'(os_u8), 32'd2040);
        chk("b2b_c_s8", 32'(os_s8), 32'h7F8);
        chk("b2b_c_n5", 32'(os_n5), 32'd5);
        step;
        chk("b2b_drain", 32'(ov_u8), 32'd0);

        // backpressure: hold the head result for five cycles
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bv = 8'(i + 1);
            d_u8 = {8{bv}};
            step;
        end
        chk("bp_head_valid", 32'(ov_u8), 32'd1);
        chk("bp_head_sum", 32'(os_u8), 32'd8);
        out_ready = 1'b0;
        d_u8 = {8{8'd4}};
        #1;
        chk("bp_ready_low", 32'(rdy_u8), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step;
            chk("bp_hold_valid", 32'(ov_u8), 32'd1);
            chk("bp_hold_sum", 32'(os_u8), 32'd8);
            chk("bp_hold_ready", 32'(rdy_u8), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_back", 32'(rdy_u8), 32'd1);
        step;
        in_valid = 1'b0;
        chk("bp_r1_valid", 32'(ov_u8), 32'd1);
        chk("bp_r1_sum", 32'(os_u8), 32'd16);
        step;
        chk("bp_r2_sum", 32'(os_u8), 32'd24);
        step;
        chk("bp_r3_valid", 32'(ov_u8), 32'd1);
        chk("bp_r3_sum", 32'(os_u8), 32'd32);
        step;
        chk("bp_drain", 32'(ov_u8), 32'd0);

        // asynchronous reset with three vectors in flight
        in_valid = 1'b1;
        d_u8 = {8{8'd1}};
        d_n5 = {5{8'd1}};
        step;
        step;
        step;
        chk("mid_pre_valid", 32'(ov_u8), 32'd1);
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ov_u8), 32'd0);
        chk("mid_rst_sum", 32'(os_u8), 32'd0);
        chk("mid_rst_n5_sum", 32'(os_n5), 32'd0);
        step;
        step;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step;
            chk("post_rst_valid", 32'(ov_u8), 32'd0);
            chk("post_rst_ready", 32'(rdy_u8), 32'd1);
        end
`else
        // frame of three beats, each summing to 8
        in_valid = 1'b1;
        d_u8 = {8{8'd1}};
        step;
        step;
        in_last = 1'b1;
        step;
        in_valid = 1'b0;
        in_last = 1'b0;
        chk("acc_e3_valid", 32'(ov_u8), 32'd0);
        step;
        chk("acc_e4_valid", 32'(ov_u8), 32'd0);
        step;
        chk("acc_e5_valid", 32'(ov_u8), 32'd0);
        step;
        chk("acc_f1_valid", 32'(ov_u8), 32'd1);
        chk("acc_f1_sum", 32'(os_u8), 32'd24);
        step;
        chk("acc_f1_drop", 32'(ov_u8), 32'd0);

        // second frame restarts from zero
        in_valid = 1'b1;
        d_u8 = {8{8'd2}};
        step;
        in_last = 1'b1;
        step;
        in_valid = 1'b0;
        in_last = 1'b0;
        step;
        step;
        chk("acc_f2_early", 32'(ov_u8), 32'd0);
        step;
        chk("acc_f2_valid", 32'(ov_u8), 32'd1);
        chk("acc_f2_sum", 32'(os_u8), 32'd32);

        // 12-bit accumulator: 2040 + 2040 + 15 + 1 wraps to 0
        v12 = 1'b1;
        d12 = {8{8'hFF}};
        step;
        step;
        d12 = {56'd0, 8'd15};
        step;
        d12 = {56'd0, 8'd1};
        l12 = 1'b1;
        step;
        v12 = 1'b0;
        l12 = 1'b0;
        step;
        step;
        chk("wrap_early", 32'(ov12), 32'd0);
        step;
        chk("wrap_valid", 32'(ov12), 32'd1);
        chk("wrap_sum", 32'(os12), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
